// File: rtl/tlk2711_pkg.sv
// Shared types and command-word layout for the TLK2711 DMA read arbiter.
// A command word is {len, addr}; addr occupies the low ADDR_WIDTH bits.
package tlk2711_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    function automatic int cmd_width(input int addr_w, input int dlen_w);
        return addr_w + dlen_w;
    endfunction

    function automatic int addr_lsb();
        return 0;
    endfunction

    function automatic int len_lsb(input int addr_w);
        return addr_w;
    endfunction

    // Width of a requester index for the supported 2..4 requesters
    function automatic int ptr_width(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/tlk2711_rr_pick.sv
// Combinational round-robin pick: first set request found searching upward
// from ptr+1 with wrap-around.
module tlk2711_rr_pick
    import tlk2711_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] win_idx,
    output logic          win_valid
);

    always_comb begin
        logic [PW-1:0] k;
        win       = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        k         = ptr;
        for (int i = 0; i < N; i++) begin
            k = (k == PW'(N - 1)) ? '0 : k + 1'b1;
            if (!win_valid && req[k]) begin
                win_valid = 1'b1;
                win[k]    = 1'b1;
                win_idx   = k;
            end
        end
    end

endmodule

// File: rtl/tlk2711_rd_arb.sv
// DMA read-channel arbiter: round-robin grants one requester, issues its
// command, then routes the read stream to it until the last beat.
//
//   state | meaning
//   IDLE  | no owner; stream drained as stray; arbitrate on any request
//   CMD   | command presented on the read command channel, awaiting ack
//   DATA  | read stream routed to the granted requester until last beat
module tlk2711_rd_arb
    import tlk2711_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 48,
    parameter int DLEN_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        i_soft_rst,
    input  logic [NUM_REQ-1:0]                          i_req,
    output logic [NUM_REQ-1:0]                          o_ack,
    input  logic [NUM_REQ*(DLEN_WIDTH+ADDR_WIDTH)-1:0]  i_cmd_data,
    output logic                                        o_rd_cmd_req,
    output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]            o_rd_cmd_data,
    input  logic                                        i_rd_cmd_ack,
    input  logic                                        i_dma_rd_valid,
    input  logic                                        i_dma_rd_last,
    input  logic [DATA_WIDTH-1:0]                       i_dma_rd_data,
    output logic                                        o_dma_rd_ready,
    output logic [NUM_REQ-1:0]                          o_rd_valid,
    output logic [NUM_REQ-1:0]                          o_rd_last,
    output logic [DATA_WIDTH-1:0]                       o_rd_data,
    input  logic [NUM_REQ-1:0]                          i_rd_ready,
    output logic [NUM_REQ-1:0]                          o_grant,
    output logic                                        o_busy,
    output logic                                        o_err_stray
);

    localparam int CW  = cmd_width(ADDR_WIDTH, DLEN_WIDTH);
    localparam int PW  = ptr_width(NUM_REQ);
    localparam int LSB = len_lsb(ADDR_WIDTH);

    arb_state_t        state, state_nxt;
    logic [PW-1:0]     ptr, gidx;
    logic [NUM_REQ-1:0] pick_win;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic              take, cmd_done, beat_last, stray;
    logic [DLEN_WIDTH-1:0] cmd_len;

    tlk2711_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req       (i_req),
        .ptr       (ptr),
        .win       (pick_win),
        .win_idx   (pick_idx),
        .win_valid (pick_valid)
    );

    assign cmd_len   = o_rd_cmd_data[LSB +: DLEN_WIDTH];
    assign o_rd_data = i_dma_rd_data;
    assign o_busy    = (state != IDLE);
    assign stray     = i_dma_rd_valid && (state != DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Arbitration waits while o_ack is still pulsing so a zero-length
    // requester that has not yet seen its ack is not granted twice.
    always_comb begin
        state_nxt      = state;
        take           = 1'b0;
        cmd_done       = 1'b0;
        beat_last      = 1'b0;
        o_dma_rd_ready = 1'b1;
        o_rd_valid     = '0;
        o_rd_last      = '0;
        case (state)
            IDLE: begin
                if (pick_valid && (o_ack == '0)) begin
                    take      = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (i_rd_cmd_ack) begin
                    cmd_done  = 1'b1;
                    state_nxt = (cmd_len == '0) ? IDLE : DATA;
                end
            end
            DATA: begin
                o_dma_rd_ready   = i_rd_ready[gidx];
                o_rd_valid[gidx] = i_dma_rd_valid;
                o_rd_last[gidx]  = i_dma_rd_last;
                if (i_dma_rd_valid && i_rd_ready[gidx] && i_dma_rd_last) begin
                    beat_last = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (i_soft_rst) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= PW'(NUM_REQ - 1);
            gidx          <= '0;
            o_grant       <= '0;
            o_ack         <= '0;
            o_rd_cmd_req  <= 1'b0;
            o_rd_cmd_data <= '0;
            o_err_stray   <= 1'b0;
        end else if (i_soft_rst) begin
            ptr          <= PW'(NUM_REQ - 1);
            o_grant      <= '0;
            o_ack        <= '0;
            o_rd_cmd_req <= 1'b0;
            o_err_stray  <= 1'b0;
        end else begin
            o_ack <= '0;
            if (stray) o_err_stray <= 1'b1;
            if (take) begin
                o_rd_cmd_data <= i_cmd_data[pick_idx*CW +: CW];
                o_grant       <= pick_win;
                gidx          <= pick_idx;
                o_rd_cmd_req  <= 1'b1;
            end
            if (cmd_done) begin
                o_rd_cmd_req <= 1'b0;
                o_ack        <= o_grant;
                if (cmd_len == '0) begin
                    o_grant <= '0;
                    ptr     <= gidx;
                end
            end
            if (beat_last) begin
                o_grant <= '0;
                ptr     <= gidx;
            end
        end
    end

endmodule
